// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 helpers for the inverse cipher core.
//                Contains the S-box tables, GF(2^8) helpers, Rcon table,
//                FSM state type and single-step key schedule functions
//                (forward and inverse).
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    // Byte x of each table lives at bits [2047-8x -: 8], i.e. {~x, 3'b111}.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [7:0] c_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4
    } fsm_state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return c_INV_SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Out-of-range indices return zero so callers never read outside 1..10.
    function automatic logic [7:0] rcon_at(input logic [3:0] idx);
        return ((idx >= 4'd1) && (idx <= 4'd10)) ? c_RCON[idx] : 8'h00;
    endfunction

    // SubWord(RotWord(w)): rotate one byte left, then substitute each byte.
    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undoes key_step_fwd: the previous word 3 must be recovered first
    // because word 0 depends on it.
    function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0]  ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_aes_round.sv
`default_nettype none
// ============================================================================
//  Module      : inv_aes_round
//  Description : Combinational AES inverse round:
//                InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
//                'last' bypasses InvMixColumns for the final round.
//  Ports       : i_state      128  state entering the round
//                i_round_key  128  round key to add
//                last         1    1 = skip InvMixColumns
//                o_state      128  state leaving the round
//  Revision    : 1.0  initial release
// ============================================================================
module inv_aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         last,
    output logic [127:0] o_state
);

    // Byte index b = 4*col + row; row r is rotated right by r columns,
    // so output column c takes its row-r byte from column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(blk[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

    logic [127:0] w_ark;
    logic [127:0] w_mix;

    assign w_ark   = inv_shift_sub(i_state) ^ i_round_key;
    assign w_mix   = {inv_mix_column(w_ark[127:96]), inv_mix_column(w_ark[95:64]),
                      inv_mix_column(w_ark[63:32]),  inv_mix_column(w_ark[31:0])};
    assign o_state = last ? w_ark : w_mix;

endmodule
`default_nettype wire

// File: rtl/main_inv_aes.sv
`default_nettype none
// ============================================================================
//  Module      : main_inv_aes
//  Description : Iterative AES-128 decryption core. Expands the cipher key
//                forward to round key 10, then runs the inverse cipher while
//                walking the key schedule backwards (no round-key storage).
//                Fixed 21-cycle start-to-done latency.
//  Ports       : clk         1    rising-edge clock
//                rst         1    asynchronous active-high reset
//                start       1    request, sampled only in IDLE
//                aes_input   128  ciphertext (byte 0 = [127:120])
//                aes_key     128  original cipher key
//                aes_output  128  plaintext, held until next completion
//                busy        1    operation in progress
//                done        1    one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module main_inv_aes
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] aes_input,
    input  logic [127:0] aes_key,
    output logic [127:0] aes_output,
    output logic         busy,
    output logic         done
);

    fsm_state_t   r_fsm;
    fsm_state_t   w_fsm_next;
    logic [3:0]   r_cnt;
    logic [127:0] r_blk;
    logic [127:0] r_key;
    logic [127:0] r_out;
    logic         r_busy;
    logic         r_done;
    logic [127:0] w_round_out;
    logic         w_last;

    assign w_last = (r_fsm == ST_FINAL);

    inv_aes_round u_round (
        .i_state     (r_blk),
        .i_round_key (r_key),
        .last        (w_last),
        .o_state     (w_round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Counter use: KEYEXP counts 0..9 (Rcon index cnt+1) and ends at 10;
    // INIT/ROUND then count 10..1, each step using Rcon[cnt] to go back one key.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE:   if (start) w_fsm_next = ST_KEYEXP;
            ST_KEYEXP: if (r_cnt == 4'd9) w_fsm_next = ST_INIT;
            ST_INIT:   w_fsm_next = ST_ROUND;
            ST_ROUND:  if (r_cnt == 4'd1) w_fsm_next = ST_FINAL;
            ST_FINAL:  w_fsm_next = ST_IDLE;
            default:   w_fsm_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_blk  <= '0;
            r_key  <= '0;
            r_out  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_blk  <= aes_input;
                        r_key  <= aes_key;
                        r_cnt  <= 4'd0;
                        r_busy <= 1'b1;
                    end
                end
                ST_KEYEXP: begin
                    r_key <= key_step_fwd(r_key, rcon_at(r_cnt + 4'd1));
                    r_cnt <= r_cnt + 4'd1;
                end
                ST_INIT: begin
                    r_blk <= r_blk ^ r_key;
                    r_key <= key_step_inv(r_key, rcon_at(r_cnt));
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_ROUND: begin
                    r_blk <= w_round_out;
                    r_key <= key_step_inv(r_key, rcon_at(r_cnt));
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_FINAL: begin
                    r_out  <= w_round_out;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign aes_output = r_out;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire
